fp_convert_arbiter: RTL and testbench



---
 rtl/fp_convert_arbiter.sv | 135 +++++++++++++
 tb/tb_fp_convert_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_convert_arbiter.sv
// Round-robin scheduler sharing one external combinational int12 -> sign/exp3/sig4 converter.
// Define FPCA_STATS_EN to add o_conv_count, a saturating count of accepted results.
module fp_convert_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [12*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [11:0]           o_conv_d,
  input  logic                  i_conv_sign,
  input  logic [2:0]            i_conv_exp,
  input  logic [3:0]            i_conv_sig,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [IDW-1:0]        o_out_id,
  output logic                  o_out_sign,
  output logic [2:0]            o_out_exp,
  output logic [3:0]            o_out_sig
`ifdef FPCA_STATS_EN
  ,
  output logic [15:0]           o_conv_count
`endif
);

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  state_t         r_state;
  state_t         w_nextState;
  logic [IDW-1:0] r_rrPtr;
  logic [IDW-1:0] w_winner;
  logic [IDW-1:0] w_nextPtr;
  logic           w_found;
  logic           w_grant;
  logic           w_outFire;
  logic [11:0]    w_reqData [NUM_REQ];

  logic [11:0]    r_convD;
  logic           r_outValid;
  logic [IDW-1:0] r_outId;
  logic           r_outSign;
  logic [2:0]     r_outExp;
  logic [3:0]     r_outSig;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_reqData[g] = i_req_data[12*g +: 12];
    end
  endgenerate

  // Circular search starting at the round-robin pointer; first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rrPtr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[(int'(r_rrPtr) + i) % NUM_REQ]) begin
        w_found  = 1'b1;
        w_winner = IDW'((int'(r_rrPtr) + i) % NUM_REQ);
      end
    end
  end

  assign w_nextPtr = (w_winner == IDW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
  assign w_grant   = (r_state == IDLE) && w_found;
  assign w_outFire = (r_state == HOLD) && i_out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    o_req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          o_req_ready[w_winner] = 1'b1;
          w_nextState           = CONVERT;
        end
      end
      CONVERT: w_nextState = HOLD;
      HOLD:    if (i_out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand stays put after the grant so the converter settles for a full period before capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrPtr    <= '0;
      r_convD    <= '0;
      r_outValid <= 1'b0;
      r_outId    <= '0;
      r_outSign  <= 1'b0;
      r_outExp   <= '0;
      r_outSig   <= '0;
    end else begin
      if (w_grant) begin
        r_convD <= w_reqData[w_winner];
        r_outId <= w_winner;
        r_rrPtr <= w_nextPtr;
      end
      if (r_state == CONVERT) begin
        r_outSign  <= i_conv_sign;
        r_outExp   <= i_conv_exp;
        r_outSig   <= i_conv_sig;
        r_outValid <= 1'b1;
      end
      if (w_outFire) r_outValid <= 1'b0;
    end
  end

`ifdef FPCA_STATS_EN
  logic [15:0] r_convCount;

  always_ff @(posedge clk) begin
    if (!rst_n)                                    r_convCount <= '0;
    else if (w_outFire && r_convCount != 16'hFFFF) r_convCount <= r_convCount + 16'd1;
  end

  assign o_conv_count = r_convCount;
`endif

  assign o_conv_d    = r_convD;
  assign o_out_valid = r_outValid;
  assign o_out_id    = r_outId;
  assign o_out_sign  = r_outSign;
  assign o_out_exp   = r_outExp;
  assign o_out_sig   = r_outSig;

endmodule

// File: tb/tb_fp_convert_arbiter.sv
// Bench for fp_convert_arbiter: converter model, cycle model, result scoreboard, directed + random traffic.
// Honors FPCA_STATS_EN the same way as the design.
module tb_fp_convert_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    reqValid;
  logic [12*NUM_REQ-1:0] reqData;
  logic [NUM_REQ-1:0]    reqReady;
  logic [11:0]           convD;
  logic                  convSign;
  logic [2:0]            convExp;
  logic [3:0]            convSig;
  logic                  outValid;
  logic                  outReady;
  logic [IDW-1:0]        outId;
  logic                  outSign;
  logic [2:0]            outExp;
  logic [3:0]            outSig;
`ifdef FPCA_STATS_EN
  logic [15:0]           convCount;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int cycle      = 0;

  int          mState  = 0;
  int          mPtr    = 0;
  logic [11:0] mConvD  = '0;
  logic [1:0]  mId     = '0;
  logic        mValid  = 1'b0;
  logic [7:0]  mFields = '0;
  logic [15:0] mCount  = '0;

  logic [15:0] sbQueue [$];
  int          grantLog [$];
  int          grantCycle [$];

  fp_convert_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (reqValid),
    .i_req_data  (reqData),
    .o_req_ready (reqReady),
    .o_conv_d    (convD),
    .i_conv_sign (convSign),
    .i_conv_exp  (convExp),
    .i_conv_sig  (convSig),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_id    (outId),
    .o_out_sign  (outSign),
    .o_out_exp   (outExp),
    .o_out_sig   (outSig)
`ifdef FPCA_STATS_EN
    ,
    .o_conv_count(convCount)
`endif
  );

  always #5 clk = ~clk;

  // Reference converter: magnitude scaled to a 4-bit significand, clamped to exp=7/sig=15.
  function automatic logic [7:0] fpConv(input logic [11:0] d);
    logic [12:0] mag;
    logic [12:0] s;
    int p;
    int e;
    mag = d[11] ? (13'd0 - {d[11], d}) : {1'b0, d};
    p = 0;
    for (int i = 0; i < 13; i++) if (mag[i]) p = i;
    if (mag < 13'd16) return {d[11], 3'd0, mag[3:0]};
    e = p - 3;
    if (e > 7) return {d[11], 3'd7, 4'd15};
    s = mag >> e;
    return {d[11], e[2:0], s[3:0]};
  endfunction

  assign {convSign, convExp, convSig} = fpConv(convD);

  function automatic int modelWinner(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int i = 0; i < NUM_REQ; i++)
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic ready);
    reqValid = valid;
    outReady = ready;
  endtask

  task automatic setData(input int k, input logic [11:0] value);
    reqData[k*12 +: 12] = value;
  endtask

  // Cycle model, advanced on the same edge the design samples its inputs.
  always @(posedge clk) begin
    int win;
    cycle++;
    if (!rst_n) begin
      mState = 0; mPtr = 0; mConvD = '0; mId = '0;
      mValid = 1'b0; mFields = '0; mCount = '0;
      sbQueue.delete();
    end else begin
      case (mState)
        0: begin
          win = modelWinner(reqValid, mPtr);
          if (win >= 0) begin
            mConvD = reqData[win*12 +: 12];
            mId    = 2'(win);
            mPtr   = (win + 1) % NUM_REQ;
            mState = 1;
          end
        end
        1: begin
          mFields = fpConv(mConvD);
          mValid  = 1'b1;
          mState  = 2;
        end
        default: begin
          if (outReady) begin
            mValid = 1'b0;
            mState = 0;
            if (mCount != 16'hFFFF) mCount++;
          end
        end
      endcase
    end
  end

  // Mid-cycle comparison against the model, plus scoreboard push on grant and pop on accept.
  always @(negedge clk) begin
    int win;
    int obs;
    logic [NUM_REQ-1:0] expReady;
    logic [15:0] item;
    win = (mState == 0) ? modelWinner(reqValid, mPtr) : -1;
    expReady = '0;
    if (win >= 0) expReady[win] = 1'b1;
    checkOutput("reqReady", 32'(reqReady), 32'(expReady));
    checkOutput("outValid", 32'(outValid), 32'(mValid));
    checkOutput("convD", 32'(convD), 32'(mConvD));
    checkOutput("outId", 32'(outId), 32'(mId));
    checkOutput("outFields", 32'({outSign, outExp, outSig}), 32'(mFields));
`ifdef FPCA_STATS_EN
    checkOutput("convCount", 32'(convCount), 32'(mCount));
`endif
    if (rst_n && reqReady != '0) begin
      obs = 0;
      for (int i = 0; i < NUM_REQ; i++) if (reqReady[i]) obs = i;
      grantLog.push_back(obs);
      grantCycle.push_back(cycle);
    end
    if (rst_n && win >= 0)
      sbQueue.push_back({8'(win), fpConv(reqData[win*12 +: 12])});
    if (rst_n && outValid && outReady) begin
      checkOutput("sbNotEmpty", 32'(sbQueue.size() > 0), 32'd1);
      if (sbQueue.size() > 0) begin
        item = sbQueue.pop_front();
        checkOutput("sbId", 32'(outId), 32'(item[15:8]));
        checkOutput("sbFields", 32'({outSign, outExp, outSig}), 32'(item[7:0]));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    reqValid = '0;
    reqData = '0;
    outReady = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstConvD", 32'(convD), 32'd0);
    checkOutput("rstId", 32'(outId), 32'd0);
    checkOutput("rstFields", 32'({outSign, outExp, outSig}), 32'd0);
    tick();
    rst_n = 1'b1;

    // Largest positive sample saturates.
    setData(0, 12'h7FF);
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("t1Ready", 32'(reqReady), 32'h1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t1ConvD", 32'(convD), 32'h7FF);
    tick();
    @(negedge clk);
    checkOutput("t1Valid", 32'(outValid), 32'd1);
    checkOutput("t1Id", 32'(outId), 32'd0);
    checkOutput("t1Fields", 32'({outSign, outExp, outSig}), 32'h7F);
    tick();

    // Most negative sample from requester 2.
    setData(2, 12'h800);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("t2Ready", 32'(reqReady), 32'h4);
    tick();
    applyStimulus(4'b0000, 1'b1);
    tick();
    @(negedge clk);
    checkOutput("t2Valid", 32'(outValid), 32'd1);
    checkOutput("t2Id", 32'(outId), 32'd2);
    checkOutput("t2Fields", 32'({outSign, outExp, outSig}), 32'hFF);
    tick();

    // Pointer sits at 3 after serving requester 2.
    grantLog.delete();
    setData(3, 12'h010);
    setData(0, 12'hF00);
    applyStimulus(4'b1001, 1'b1);
    repeat (6) tick();
    applyStimulus(4'b0000, 1'b1);
    repeat (2) tick();
    checkOutput("t4Count", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() == 2) begin
      checkOutput("t4First", 32'(grantLog[0]), 32'd3);
      checkOutput("t4Second", 32'(grantLog[1]), 32'd0);
    end

    // Everyone valid after reset.
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    grantLog.delete();
    grantCycle.delete();
    for (int k = 0; k < NUM_REQ; k++) setData(k, 12'(100 * k + 37));
    applyStimulus(4'b1111, 1'b1);
    repeat (15) tick();
    applyStimulus(4'b0000, 1'b1);
    repeat (3) tick();
    checkOutput("t3Count", 32'(grantLog.size()), 32'd5);
    if (grantLog.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput("t3Order", 32'(grantLog[i]), 32'(i % NUM_REQ));
        if (i > 0) checkOutput("t3Spacing", 32'(grantCycle[i] - grantCycle[i-1]), 32'd3);
      end
    end

    // Backpressure in HOLD.
    setData(1, 12'h0A5);
    applyStimulus(4'b0010, 1'b0);
    tick();
    applyStimulus(4'b1111, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bpValid", 32'(outValid), 32'd1);
      checkOutput("bpReady", 32'(reqReady), 32'd0);
      checkOutput("bpId", 32'(outId), 32'd1);
      checkOutput("bpFields", 32'({outSign, outExp, outSig}), 32'h4A);
      tick();
    end
    outReady = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("bpNextGrant", 32'(reqReady), 32'h4);
    tick();
    applyStimulus(4'b0000, 1'b1);
    repeat (4) tick();

    // Reset while in CONVERT discards the sample and rewinds the pointer.
    setData(0, 12'h123);
    applyStimulus(4'b0001, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("rcValid", 32'(outValid), 32'd0);
    checkOutput("rcPtr", 32'(reqReady), 32'h1);
    tick();
    applyStimulus(4'b0000, 1'b1);
    repeat (4) tick();

    // Three accepted results from a clean reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      setData(k, 12'(12'h321 + k));
      applyStimulus(4'(1 << k), 1'b1);
      tick();
      applyStimulus(4'b0000, 1'b1);
      repeat (2) tick();
    end
`ifdef FPCA_STATS_EN
    @(negedge clk);
    checkOutput("statsCount", 32'(convCount), 32'd3);
`endif

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      reqValid = 4'($urandom_range(0, 15));
      for (int k = 0; k < NUM_REQ; k++) setData(k, 12'($urandom));
      outReady = ($urandom_range(0, 9) < 7);
      tick();
    end
    applyStimulus(4'b0000, 1'b1);
    repeat (6) tick();
    checkOutput("sbDrained", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
